// File: rtl/irq_controller.sv
// irq_controller: synchronises, latches, masks and prioritises interrupt sources into a single-cycle core pulse
module irq_controller #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [4:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [31:0]        reg_rdata,
  output logic               interrupt,
  output logic [ID_W-1:0]    active_id,
  output logic               in_service
);
  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SERVICE} state_t;
  state_t r_state, w_next;
  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_hist, r_pend_edge, r_enable, r_mode;
  logic [NUM_SRC-1:0] w_sync, w_rise, w_pending, w_eligible, w_w1c, w_claim;
  logic               r_gie;
  logic [ID_W-1:0]    r_active_id, w_winner;
  logic [31:0]        r_rdata, w_rdata;
  logic [2:0]         w_idx;
  logic               w_eoi, w_unused;
  assign w_idx      = reg_addr[4:2];
  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync & ~r_hist;
  assign w_pending  = (r_pend_edge & r_mode) | (w_sync & ~r_mode);
  assign w_eligible = w_pending & r_enable & {NUM_SRC{r_gie}};
  assign w_w1c      = (reg_we && w_idx == 3'd3) ? reg_wdata[NUM_SRC-1:0] & r_mode : '0;
  assign w_claim    = (r_state == S_FIRE) ? NUM_SRC'(1) << r_active_id : '0;
  assign w_eoi      = reg_we && w_idx == 3'd5 && reg_wdata[ID_W-1:0] == r_active_id;
  assign w_unused   = &{1'b0, reg_wdata, reg_addr[1:0]};
  assign w_rdata = w_idx == 3'd0 ? {31'b0, r_gie} :
                   w_idx == 3'd1 ? 32'(r_enable) :
                   w_idx == 3'd2 ? 32'(r_mode) :
                   w_idx == 3'd3 ? 32'(w_pending) :
                   w_idx == 3'd4 ? {in_service, {(31-ID_W){1'b0}}, r_active_id} : '0;
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (w_eligible[i]) w_winner = ID_W'(i);
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (|w_eligible ? S_FIRE : S_IDLE) :
             r_state == S_FIRE ? S_SERVICE : (w_eoi ? S_IDLE : S_SERVICE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '{default: '0};
      r_hist      <= '0;
      r_pend_edge <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_gie       <= 1'b0;
      r_rdata     <= '0;
      r_state     <= S_IDLE;
      r_active_id <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= w_sync;
      // a fresh rise wins over a same-cycle W1C or claim
      r_pend_edge <= (r_pend_edge & ~w_w1c & ~w_claim) | (w_rise & r_mode);
      if (reg_we && w_idx == 3'd0) r_gie <= reg_wdata[0];
      if (reg_we && w_idx == 3'd1) r_enable <= reg_wdata[NUM_SRC-1:0];
      if (reg_we && w_idx == 3'd2) r_mode <= reg_wdata[NUM_SRC-1:0];
      if (reg_re) r_rdata <= w_rdata;
      r_state <= w_next;
      if (r_state == S_IDLE && |w_eligible) r_active_id <= w_winner;
    end
  end
  assign interrupt  = r_state == S_FIRE;
  assign in_service = r_state == S_SERVICE;
  assign active_id  = r_active_id;
  assign reg_rdata  = r_rdata;
endmodule
